// File: rtl/bank_req_selector_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bank_req_selector_pkg
//  Purpose  : Shared constants and types for the bank scheduler front end:
//             request type encodings, default geometry (row width, FIFO
//             counts), request field positions/widths and request sizes.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package bank_req_selector_pkg;

  // Request type encodings
  localparam logic TYPE_READ  = 1'b1;
  localparam logic TYPE_WRITE = 1'b0;

  typedef enum logic {
    REQ_WRITE = 1'b0,
    REQ_READ  = 1'b1
  } req_type_e;

  // Default bank geometry
  localparam int DEF_RA_BITS    = 16;
  localparam int DEF_ARR_NUM_RD = 4;
  localparam int DEF_ARR_NUM_WR = 3;
  localparam int DEF_NUM_BUF    = DEF_ARR_NUM_RD + DEF_ARR_NUM_WR;

  // Request field widths
  localparam int RA_W    = DEF_RA_BITS;
  localparam int CA_W    = 10;
  localparam int BA_W    = 2;
  localparam int BG_W    = 2;
  localparam int CID_W   = 3;
  localparam int TYPE_W  = 1;
  localparam int INDEX_W = 8;
  localparam int DATA_W  = 64;

  // Request field positions (row address sits at bit 0)
  localparam int RA_POS    = 0;
  localparam int CA_POS    = RA_POS    + RA_W;
  localparam int BA_POS    = CA_POS    + CA_W;
  localparam int BG_POS    = BA_POS    + BA_W;
  localparam int CID_POS   = BG_POS    + BG_W;
  localparam int TYPE_POS  = CID_POS   + CID_W;
  localparam int INDEX_POS = TYPE_POS  + TYPE_W;
  localparam int DATA_POS  = INDEX_POS + INDEX_W;

  // Read requests carry no payload; writes append the data field
  localparam int RD_REQ_SIZE = DATA_POS;
  localparam int WR_REQ_SIZE = DATA_POS + DATA_W;

  // Anything other than the read encoding is treated as a write
  function automatic logic is_read(input logic req_type, input logic read_enc);
    return (req_type == read_enc);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bank_req_selector_prio_onehot.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : prio_onehot
//  Purpose  : Lowest-index-first one-hot selector with an any-request flag.
//  Ports    : req_i [N] request vector
//             gnt_o [N] one-hot grant of lowest set request bit (zero if none)
//             any_o      at least one request bit set
//  Revision : 1.0 - initial release
// ============================================================================
module prio_onehot #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic         any_o
);

  // Two's-complement trick: req & -req isolates the lowest set bit
  assign gnt_o = req_i & (~req_i + N'(1));
  assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/bank_req_selector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bank_req_selector
//  Purpose  : Steers each incoming request to one per-bank FIFO. Reads use
//             FIFOs 0..ARR_NUM_RD-1, writes use the remaining ones. A FIFO
//             whose newest entry is on the same row (and is neither full nor
//             draining) is preferred; otherwise the lowest empty FIFO of the
//             right type is opened. Purely combinational.
//  Ports    : clk        clock (no state is held)
//             rst_n      reset, ACTIVE-HIGH, forces push to zero
//             valid      request valid
//             in_type    request type (READ encoding or anything else=write)
//             in_addr    request row address
//             empty/full/mid [NUM_BUF]  per-FIFO status
//             last_addr  [NUM_BUF*RA_BITS] newest row per FIFO
//             push       [NUM_BUF] one-hot-or-zero FIFO write enable
//  Revision : 1.0 - initial release
// ============================================================================
module bank_req_selector
  import bank_req_selector_pkg::*;
#(
  parameter int   RA_BITS    = DEF_RA_BITS,
  parameter int   RA_POS     = 0,
  parameter logic READ       = TYPE_READ,
  parameter logic WRITE      = TYPE_WRITE,
  parameter int   ARR_NUM_RD = DEF_ARR_NUM_RD,
  parameter int   ARR_NUM_WR = DEF_ARR_NUM_WR
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        valid,
  input  logic                                        in_type,
  input  logic [RA_BITS-1:0]                          in_addr,
  input  logic [ARR_NUM_RD+ARR_NUM_WR-1:0]            empty,
  input  logic [ARR_NUM_RD+ARR_NUM_WR-1:0]            full,
  input  logic [ARR_NUM_RD+ARR_NUM_WR-1:0]            mid,
  input  logic [(ARR_NUM_RD+ARR_NUM_WR)*RA_BITS-1:0]  last_addr,
  output logic [ARR_NUM_RD+ARR_NUM_WR-1:0]            push
);

  localparam int NUM_BUF = ARR_NUM_RD + ARR_NUM_WR;

  logic [NUM_BUF-1:0]    w_hit;
  logic [ARR_NUM_RD-1:0] w_rd_hit_gnt, w_rd_emp_gnt, w_rd_sel;
  logic [ARR_NUM_WR-1:0] w_wr_hit_gnt, w_wr_emp_gnt, w_wr_sel;
  logic                  w_rd_hit_any, w_rd_emp_any;
  logic                  w_wr_hit_any, w_wr_emp_any;
  logic                  w_is_read;

  // clk and the informational parameters carry no logic in this block
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, (RA_POS >= 0), WRITE};

  // Row hit: FIFO still open for batching and its newest row matches.
  // A draining (mid) FIFO is closed so the batch is not extended behind a pop.
  for (genvar i = 0; i < NUM_BUF; i++) begin : g_hit
    assign w_hit[i] = !empty[i] && !full[i] && !mid[i] &&
                      (last_addr[i*RA_BITS +: RA_BITS] == in_addr);
  end

  prio_onehot #(.N(ARR_NUM_RD)) u_rd_hit (
    .req_i (w_hit[ARR_NUM_RD-1:0]),
    .gnt_o (w_rd_hit_gnt),
    .any_o (w_rd_hit_any)
  );

  prio_onehot #(.N(ARR_NUM_RD)) u_rd_emp (
    .req_i (empty[ARR_NUM_RD-1:0]),
    .gnt_o (w_rd_emp_gnt),
    .any_o (w_rd_emp_any)
  );

  prio_onehot #(.N(ARR_NUM_WR)) u_wr_hit (
    .req_i (w_hit[NUM_BUF-1:ARR_NUM_RD]),
    .gnt_o (w_wr_hit_gnt),
    .any_o (w_wr_hit_any)
  );

  prio_onehot #(.N(ARR_NUM_WR)) u_wr_emp (
    .req_i (empty[NUM_BUF-1:ARR_NUM_RD]),
    .gnt_o (w_wr_emp_gnt),
    .any_o (w_wr_emp_any)
  );

  // Hit beats open-batch; if neither exists the grant vector is all zero
  // and the request is dropped.
  assign w_rd_sel  = w_rd_hit_any ? w_rd_hit_gnt :
                     (w_rd_emp_any ? w_rd_emp_gnt : '0);
  assign w_wr_sel  = w_wr_hit_any ? w_wr_hit_gnt :
                     (w_wr_emp_any ? w_wr_emp_gnt : '0);
  assign w_is_read = is_read(in_type, READ);

  always_comb begin
    push = '0;
    if (!rst_n && valid) begin
      if (w_is_read) push[ARR_NUM_RD-1:0]       = w_rd_sel;
      else           push[NUM_BUF-1:ARR_NUM_RD] = w_wr_sel;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bank_req_selector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bank_req_selector
//  Purpose  : Directed and random check of bank_req_selector against four
//             depth-4 read FIFOs and three depth-2 write FIFOs modelled here.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bank_req_selector;

  localparam int RA  = 16;
  localparam int NRD = 4;
  localparam int NWR = 3;
  localparam int NB  = NRD + NWR;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  logic          in_type;
  logic [RA-1:0] in_addr;
  logic [NB-1:0] empty, full, mid, push, pop;
  logic [NB*RA-1:0] last_addr;

  // FIFO occupancy model
  int            cnt   [NB];
  logic [RA-1:0] last  [NB];
  logic          mid_q [NB];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bank_req_selector #(
    .RA_BITS(RA), .RA_POS(0), .READ(1'b1), .WRITE(1'b0),
    .ARR_NUM_RD(NRD), .ARR_NUM_WR(NWR)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .in_type(in_type),
    .in_addr(in_addr), .empty(empty), .full(full), .mid(mid),
    .last_addr(last_addr), .push(push)
  );

  function automatic int depth(input int i);
    return (i < NRD) ? 4 : 2;
  endfunction

  always_comb begin
    empty     = '0;
    full      = '0;
    mid       = '0;
    last_addr = '0;
    for (int i = 0; i < NB; i++) begin
      empty[i] = (cnt[i] == 0);
      full[i]  = (cnt[i] == depth(i));
      mid[i]   = mid_q[i];
      last_addr[i*RA +: RA] = last[i];
    end
  end

  // mid is set by a pop and cleared once the FIFO drains empty
  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (rst_n) begin
        cnt[i]   <= 0;
        mid_q[i] <= 1'b0;
        last[i]  <= '0;
      end else begin
        cnt[i] <= cnt[i] + (push[i] ? 1 : 0) - ((pop[i] && cnt[i] != 0) ? 1 : 0);
        if (push[i]) last[i] <= in_addr;
        mid_q[i] <= ((cnt[i] + (push[i] ? 1 : 0) - ((pop[i] && cnt[i] != 0) ? 1 : 0)) != 0)
                    && (mid_q[i] || (pop[i] && cnt[i] != 0));
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs mid-period, check push, then let the edge occur
  task automatic cyc(input string tag, input logic r, input logic v, input logic t,
                     input logic [RA-1:0] a, input logic [NB-1:0] p,
                     input logic [NB-1:0] exp);
    @(negedge clk);
    rst_n = r; valid = v; in_type = t; in_addr = a; pop = p;
    #1;
    chk(tag, 32'(push), 32'(exp));
    @(posedge clk);
  endtask

  // Independent reference: scan the type group for a hit, then for an empty FIFO
  function automatic logic [NB-1:0] ref_push(input logic r, input logic v,
                                             input logic t, input logic [RA-1:0] a);
    logic [NB-1:0] res;
    int lo, hi;
    res = '0;
    if (r || !v) return res;
    lo = t ? 0 : NRD;
    hi = t ? NRD : NB;
    for (int i = lo; i < hi; i++)
      if (cnt[i] != 0 && cnt[i] != depth(i) && !mid_q[i] && last[i] == a) begin
        res[i] = 1'b1;
        return res;
      end
    for (int i = lo; i < hi; i++)
      if (cnt[i] == 0) begin
        res[i] = 1'b1;
        return res;
      end
    return res;
  endfunction

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  initial begin
    rst_n = 1'b1; valid = 1'b0; in_type = RD; in_addr = '0; pop = '0;
    repeat (2) @(posedge clk);

    // Reset holds push low regardless of a valid request
    cyc("reset_rd", 1'b1, 1'b1, RD, 16'h1234, '0, 7'b0000000);
    cyc("reset_wr", 1'b1, 1'b1, WR, 16'h1234, '0, 7'b0000000);

    cyc("first_rd",  1'b0, 1'b1, RD, 16'h1234, '0, 7'b0000001);
    cyc("rd_hit",    1'b0, 1'b1, RD, 16'h1234, '0, 7'b0000001);
    cyc("rd_newrow", 1'b0, 1'b1, RD, 16'h5678, '0, 7'b0000010);

    cyc("wr_open",   1'b0, 1'b1, WR, 16'h1234, '0, 7'b0010000);
    cyc("wr_hit",    1'b0, 1'b1, WR, 16'h1234, '0, 7'b0010000);
    cyc("wr_full",   1'b0, 1'b1, WR, 16'h1234, '0, 7'b0100000);

    // Pop FIFO 0 with no request: closes its batch
    cyc("idle_pop",  1'b0, 1'b0, RD, 16'h1234, 7'b0000001, 7'b0000000);
    cyc("mid_skip",  1'b0, 1'b1, RD, 16'h1234, '0, 7'b0000100);

    cyc("rd_last",   1'b0, 1'b1, RD, 16'h9999, '0, 7'b0001000);
    cyc("no_room",   1'b0, 1'b1, RD, 16'hAAAA, '0, 7'b0000000);
    cyc("wr_route",  1'b0, 1'b1, WR, 16'h7777, '0, 7'b1000000);
    cyc("wr_hit5",   1'b0, 1'b1, WR, 16'h1234, '0, 7'b0100000);
    cyc("rd_hit1",   1'b0, 1'b1, RD, 16'h5678, '0, 7'b0000010);
    cyc("rd_hit2",   1'b0, 1'b1, RD, 16'h1234, '0, 7'b0000100);
    cyc("novalid",   1'b0, 1'b0, WR, 16'h7777, '0, 7'b0000000);

    // Random traffic, periodically reset so FIFOs refill from empty
    for (int k = 0; k < 200; k++) begin
      logic          r, t;
      logic [RA-1:0] a;
      logic [NB-1:0] e;
      logic [3:0][RA-1:0] rows;
      rows = {16'h0001, 16'hAAAA, 16'h5678, 16'h1234};
      r = (k % 40 == 0);
      t = 1'($urandom_range(0, 1));
      a = rows[$urandom_range(0, 3)];
      @(negedge clk);
      rst_n = r; valid = 1'b1; in_type = t; in_addr = a; pop = '0;
      #1;
      e = ref_push(r, 1'b1, t, a);
      chk("rnd_push", 32'(push), 32'(e));
      chk("rnd_onehot", 32'($countones(push) <= 1), 32'd1);
      chk("rnd_type", 32'(push & (t ? 7'b1110000 : 7'b0001111)), 32'd0);
      @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
